raster_scanout: RTL and testbench

- Read-side counterpart of the font/raster writers: walks the raster framebuffer in display order and emits a pixel stream with aligned hsync/vsync/blank.
- Generates the video timing, issues one read per visible pixel to the raster RAM's read port, and re-times the sync/blank pipeline to match RAM read latency.
- Sits between the dual-port raster RAM (write side owned by the character/graphics writers) and the DAC/video output.

---
 rtl/raster_scanout_if.sv | 13 +
 rtl/raster_scanout.sv | 224 ++++++++++++++++++++++
 tb/tb_raster_scanout.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/raster_scanout_if.sv
// Read port of the dual-port raster RAM as seen by the scanout engine.
// The master drives address and strobe; the slave returns data a fixed latency later.
interface raster_scanout_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] raster_addr;
    logic                  raster_re;
    logic [DATA_WIDTH-1:0] raster_rdata;

    modport master (output raster_addr, output raster_re, input raster_rdata);
    modport slave  (input raster_addr, input raster_re, output raster_rdata);
endinterface

// File: rtl/raster_scanout.sv
// Raster framebuffer scanout: video timing, one RAM read per visible pixel, sync/blank re-timed to RAM latency.
// Optional pixel/line doubling when RASTER_SCANOUT_DOUBLE_EN is defined.
module raster_scanout #(
    parameter int RASTER_ADDR_WIDTH = 18,
    parameter int RASTER_LINE_WIDTH = 640,
    parameter int RASTER_DATA_WIDTH = 16,
    parameter int H_VISIBLE         = 640,
    parameter int H_FRONT           = 16,
    parameter int H_SYNC            = 96,
    parameter int H_BACK            = 48,
    parameter int V_VISIBLE         = 400,
    parameter int V_FRONT           = 12,
    parameter int V_SYNC            = 2,
    parameter int V_BACK            = 35,
    parameter int READ_LATENCY      = 2
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         enable,
    input  logic [RASTER_ADDR_WIDTH-1:0] fb_base,
    raster_scanout_if.master             ram,
    output logic [RASTER_DATA_WIDTH-1:0] pix_data,
    output logic                         pix_de,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int AW      = RASTER_ADDR_WIDTH;
    localparam int DW      = RASTER_DATA_WIDTH;
    localparam int DLY     = 2 + READ_LATENCY;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS      = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_VIS_LAST = HW'(H_VISIBLE - 1);
    localparam logic [HW-1:0] H_SYNC_LO  = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_HI  = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS      = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_LO  = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_HI  = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [AW-1:0] LINE_INC   = AW'(RASTER_LINE_WIDTH);

    typedef enum logic {ST_OFF = 1'b0, ST_RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic [AW-1:0]   ptr_q, ptr_d, line_base_q, line_base_d, raster_addr_q, raster_addr_d;
    logic            raster_re_q, raster_re_d;
    logic [DLY-1:0]  de_pipe_q, de_pipe_d, hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d, fs_pipe_q, fs_pipe_d;
    logic [DLY-2:0]  run_pipe_q, run_pipe_d, re_pipe_q, re_pipe_d;
    logic [DW-1:0]   pix_data_q, pix_data_d;
    logic            vis_s, hs_n_s, vs_n_s, first_s, line_end_s, boundary_s, load_s;

    // Counter-stage decode of the current (h,v) position.
    always_comb begin
        vis_s      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hs_n_s     = !((h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI));
        vs_n_s     = !((v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI));
        first_s    = (h_cnt_q == '0) && (v_cnt_q == '0);
        line_end_s = (h_cnt_q == H_VIS_LAST) && (v_cnt_q < V_VIS);
        boundary_s = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    end

    // Free-running h/v timing counters.
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VW'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
        end
    end

    // Scanout FSM: enable and fb_base only take effect on the last cycle of a frame.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (boundary_s && enable) begin
                    state_d = ST_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_RUN: begin
                if (boundary_s) begin
                    if (enable) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Read address generation; ptr is the next word to fetch, line_base the start of the current raster line.
    always_comb begin
        ptr_d         = ptr_q;
        line_base_d   = line_base_q;
        raster_addr_d = raster_addr_q;
        raster_re_d   = 1'b0;
        if ((state_q == ST_RUN) && vis_s) begin
`ifdef RASTER_SCANOUT_DOUBLE_EN
            if (!h_cnt_q[0]) begin
                raster_addr_d = ptr_q;
                raster_re_d   = 1'b1;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
            // Even display lines replay the same raster line; odd lines move on.
            if (line_end_s) begin
                if (!v_cnt_q[0]) begin
                    ptr_d = line_base_q;
                end else begin
                    line_base_d = line_base_q + LINE_INC;
                    ptr_d       = line_base_q + LINE_INC;
                end
            end else begin
                line_base_d = line_base_q;
            end
`else
            raster_addr_d = ptr_q;
            raster_re_d   = 1'b1;
            if (line_end_s) begin
                line_base_d = line_base_q + LINE_INC;
                ptr_d       = line_base_q + LINE_INC;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
`endif
        end else if (load_s) begin
            ptr_d       = fb_base;
            line_base_d = fb_base;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Delay lines so every output refers to the same (h,v) as the RAM data arriving with it.
    always_comb begin
        de_pipe_d  = {de_pipe_q[DLY-2:0], vis_s};
        hs_pipe_d  = {hs_pipe_q[DLY-2:0], hs_n_s};
        vs_pipe_d  = {vs_pipe_q[DLY-2:0], vs_n_s};
        fs_pipe_d  = {fs_pipe_q[DLY-2:0], first_s};
        run_pipe_d = {run_pipe_q[DLY-3:0], state_q == ST_RUN};
        re_pipe_d  = {re_pipe_q[DLY-3:0], raster_re_d};
        if (de_pipe_q[DLY-2] && run_pipe_q[DLY-2]) begin
            if (re_pipe_q[DLY-2]) begin
                pix_data_d = ram.raster_rdata;
            end else begin
                pix_data_d = pix_data_q;
            end
        end else begin
            pix_data_d = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, address and output pipeline registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            ptr_q         <= '0;
            line_base_q   <= '0;
            raster_addr_q <= '0;
            raster_re_q   <= 1'b0;
            de_pipe_q     <= '0;
            hs_pipe_q     <= '1;
            vs_pipe_q     <= '1;
            fs_pipe_q     <= '0;
            run_pipe_q    <= '0;
            re_pipe_q     <= '0;
            pix_data_q    <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            ptr_q         <= ptr_d;
            line_base_q   <= line_base_d;
            raster_addr_q <= raster_addr_d;
            raster_re_q   <= raster_re_d;
            de_pipe_q     <= de_pipe_d;
            hs_pipe_q     <= hs_pipe_d;
            vs_pipe_q     <= vs_pipe_d;
            fs_pipe_q     <= fs_pipe_d;
            run_pipe_q    <= run_pipe_d;
            re_pipe_q     <= re_pipe_d;
            pix_data_q    <= pix_data_d;
        end
    end

    assign ram.raster_addr = raster_addr_q;
    assign ram.raster_re   = raster_re_q;
    assign pix_data        = pix_data_q;
    assign pix_de          = de_pipe_q[DLY-1];
    assign hsync           = hs_pipe_q[DLY-1];
    assign vsync           = vs_pipe_q[DLY-1];
    assign frame_start     = fs_pipe_q[DLY-1];
endmodule

// File: tb/tb_raster_scanout.sv
// Randomized bench for raster_scanout on a shrunken video timing, checked every cycle against a
// position-based model (frame/line/pixel arithmetic) plus a few hand-computed pins.
module tb_raster_scanout;
    localparam int AW = 18, DW = 16, LW = 10, RL = 2;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2, VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB, FT = HT * VT, DLY = 2 + RL;
`ifdef RASTER_SCANOUT_DOUBLE_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif
    localparam logic [AW-1:0] WRAP_BASE = DBL ? 18'h3FFFE : 18'h3FFFC;
    localparam int WRAP_H = 4, PREV_H = DBL ? 2 : 3, PIN_V = DBL ? 2 : 1;
    localparam int LAST_PIX = DBL ? 13 : 37, RE_PER_FRAME = DBL ? 16 : 32;

    logic          clk = 1'b0;
    logic          srst, enable;
    logic [AW-1:0] fb_base;
    logic [DW-1:0] pix_data;
    logic          pix_de, hsync, vsync, frame_start;

    raster_scanout_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_if ();

    raster_scanout #(
        .RASTER_ADDR_WIDTH(AW), .RASTER_LINE_WIDTH(LW), .RASTER_DATA_WIDTH(DW),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .srst(srst), .enable(enable), .fb_base(fb_base), .ram(ram_if.master),
        .pix_data(pix_data), .pix_de(pix_de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return a[15:0] ^ {a[17:16], 14'h0};
    endfunction

    // RAM read port: data for a strobed address appears RL cycles later; garbage otherwise.
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        rd_pipe[0] <= ram_if.raster_re ? data_of(ram_if.raster_addr) : DW'($urandom);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_if.raster_rdata = rd_pipe[RL-1];

    int n_checks = 0, n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-frame decisions as sampled on each frame's last cycle.
    bit            run_arr  [64];
    logic [AW-1:0] base_arr [64];
    int            epoch = 0;

    function automatic logic [AW-1:0] exp_addr(input int c);
        int h, v, f, row, col;
        h = c % HT; v = (c / HT) % VT; f = c / FT;
        row = DBL ? v / 2 : v;
        col = DBL ? h / 2 : h;
        return AW'(int'(base_arr[f]) + row * LW + col);
    endfunction

    bit prev_srst = 1'b1;
    int n = 0, hs_low = 0, vs_low = 0, re_cnt3 = 0, re_cnt4 = 0;

    always @(negedge clk) begin
        int c, h, v, f;
        bit vis, re_exp;
        logic [DW-1:0] exp_pix;
        if (prev_srst) begin
            n = 0;
            run_arr[0] = 1'b0;
        end else begin
            n = n + 1;
        end
        prev_srst = srst;
        if ((n % FT == FT - 1) && (n / FT + 1 < 64)) begin
            run_arr[n / FT + 1]  = enable;
            base_arr[n / FT + 1] = fb_base;
        end

        // read port, one cycle behind the counter
        c = n - 1;
        if (c < 0) begin
            check("re_reset", 32'(ram_if.raster_re), 32'd0);
            check("addr_reset", 32'(ram_if.raster_addr), 32'd0);
        end else begin
            h = c % HT; v = (c / HT) % VT; f = c / FT;
            vis = (h < HV) && (v < VV);
            re_exp = run_arr[f] && vis && (!DBL || (h % 2 == 0));
            check("raster_re", 32'(ram_if.raster_re), 32'(re_exp));
            if (re_exp) check("raster_addr", 32'(ram_if.raster_addr), 32'(exp_addr(c)));
            if (epoch == 0) begin
                if (f == 3 && ram_if.raster_re) re_cnt3++;
                if (f == 4 && ram_if.raster_re) re_cnt4++;
                if (f == 3 && v == 0 && h == WRAP_H) check("pin_wrap_zero", 32'(ram_if.raster_addr), 32'h0);
                if (f == 3 && v == 0 && h == PREV_H) check("pin_wrap_top", 32'(ram_if.raster_addr), 32'h3FFFF);
                if (c == 4 * FT) check("pin_reads_full_frame", 32'(re_cnt3), 32'(RE_PER_FRAME));
                if (c == 5 * FT) check("pin_reads_off_frame", 32'(re_cnt4), 32'd0);
            end
        end

        // video outputs, DLY cycles behind the counter
        c = n - DLY;
        if (c < 0) begin
            check("hsync_reset", 32'(hsync), 32'd1);
            check("vsync_reset", 32'(vsync), 32'd1);
            check("de_reset", 32'(pix_de), 32'd0);
            check("fs_reset", 32'(frame_start), 32'd0);
            check("pix_reset", 32'(pix_data), 32'd0);
        end else begin
            h = c % HT; v = (c / HT) % VT; f = c / FT;
            vis = (h < HV) && (v < VV);
            exp_pix = (run_arr[f] && vis) ? data_of(exp_addr(c)) : '0;
            check("hsync", 32'(hsync), 32'(!(h >= HV + HF && h < HV + HF + HS)));
            check("vsync", 32'(vsync), 32'(!(v >= VV + VF && v < VV + VF + VS)));
            check("pix_de", 32'(pix_de), 32'(vis));
            check("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
            check("pix_data", 32'(pix_data), 32'(exp_pix));
            if (epoch == 0) begin
                if (c < 2 * FT && !hsync) hs_low++;
                if (c < 2 * FT && !vsync) vs_low++;
                if (c == 2 * FT) begin
                    check("pin_hsync_low_2frames", 32'(hs_low), 32'd48);
                    check("pin_vsync_low_2frames", 32'(vs_low), 32'd60);
                    check("pin_first_fs", 32'(frame_start), 32'd1);
                    check("pin_first_de", 32'(pix_de), 32'd1);
                    check("pin_first_pix", 32'(pix_data), 32'd0);
                end
                if (f == 2 && h == 0 && v == PIN_V) check("pin_line_start", 32'(pix_data), 32'd10);
                if (f == 2 && h == HV - 1 && v == VV - 1) check("pin_last_pix", 32'(pix_data), 32'(LAST_PIX));
                if (f == 4 && h == 0 && v == 0) begin
                    check("pin_off_de", 32'(pix_de), 32'd1);
                    check("pin_off_pix", 32'(pix_data), 32'd0);
                end
            end
        end
    end

    function automatic logic [AW-1:0] rnd_base();
        if ($urandom_range(0, 1) == 1) return AW'(18'h3FFFF - AW'($urandom_range(0, 30)));
        return AW'($urandom);
    endfunction

    task automatic drive0(input int fr, input int w);
        bit bnd;
        bnd = (w == FT - 1);
        enable  = 1'($urandom);
        fb_base = AW'($urandom);
        case (fr)
            0: enable = 1'b0;
            1: begin
                enable = bnd;
                if (bnd) fb_base = '0;
            end
            2: if (bnd) begin
                enable  = 1'b1;
                fb_base = WRAP_BASE;
            end
            3: enable = (w < 2 * HT);
            default: if (bnd) fb_base = rnd_base();
        endcase
    endtask

    initial begin
        int rst_at;
        srst = 1'b1; enable = 1'b0; fb_base = '0;
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;
        rst_at = 12 * FT + $urandom_range(20, 100);
        for (int sn = 0; sn < rst_at; sn++) begin
            drive0(sn / FT, sn % FT);
            @(posedge clk);
            #1;
        end
        srst = 1'b1;
        epoch = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        srst = 1'b0;
        for (int sn = 0; sn < 8 * FT; sn++) begin
            enable  = 1'($urandom);
            fb_base = (sn % FT == FT - 1) ? rnd_base() : AW'($urandom);
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
